sub_serial: RTL
===============

# sub_serial

Bit-serial two's-complement subtractor computing d = a − b − bi, one bit per clock, LSB first. It is the subtract-direction counterpart of the 32-bit ripple-carry adder in the arithmetic library. It trades WIDTH cycles of latency for a single full-subtractor cell and one borrow flip-flop. A start/busy/done handshake lets a sequencing controller issue operands and collect the difference, borrow-out and flags.

## Interface
- width, 32, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  operation request; sampled only in IDLE
- a  input  width  minuend; captured on accepted start
- b  input  width  subtrahend; captured on accepted start
- bi  input  1  borrow-in; captured on accepted start
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- done  output  1  one-cycle pulse; results are valid from this cycle onward
- d  output  width  difference a − b − bi mod 2^width
- bo  output  1  borrow-out (1 when the unsigned a < b + bi)
- ovf  output  1  signed overflow of a − b − bi
- zero  output  1  d == 0

## Operation
- FSM states:
  - IDLE: start=1 → RUN; capture a, b into shift registers; borrow flop ← bi; bit counter ← 0; latch a[width−1] and b[width−1] for ovf.
  - RUN: process one bit per cycle.
    - Full-subtractor cell inputs: x = a_sh[0], y = b_sh[0], br = borrow flop.
    - diff = x^y^br; borrow_next = (~x&y) | (~(x^y)&br).
    - d_sh shifts right with diff inserted at bit width−1. a_sh and b_sh shift right.
    - counter increments. At counter == width−1 → DONE.
  - DONE: done=1 for exactly one cycle; → IDLE unconditionally.
- Output load on the RUN→DONE edge:
  - d ← final shifted value
  - bo ← final borrow
  - ovf ← (a_msb ^ b_msb) & (d[width−1] ^ a_msb)
  - zero ← (d == 0)
- Outputs d/bo/ovf/zero hold their values until the next completion. They do not change during a subsequent RUN.
- start while busy, including in DONE, is ignored. There is no queuing and no error indication.
- The counter is ceil(log2(width)) bits. Counter wrap never occurs because the RUN exit is decoded at width−1.

## Timing
- Reset (rst_n=0, asynchronous) sets: state IDLE, busy=0, done=0, d=0, bo=0, ovf=0, zero=0, internal shift registers/counter/borrow=0.
- Reset deassertion is synchronized externally. The first sampled edge after release may accept start.
- start sampled high at edge E0 → busy=1 after E0 → RUN occupies edges E1..Ewidth → done=1 and results valid after edge Ewidth.
- Latency is start-edge to done-high of width cycles, plus one DONE cycle.
- Minimum issue interval is width+2 cycles: start is next accepted at edge Ewidth+2, while back in IDLE.
- Reset asserted mid-RUN or in DONE aborts immediately. All outputs return to reset values and no done pulse is produced.
- bi is used only as the initial borrow. a/b/bi may change freely after the accepting edge.

## Structure
- Shared package arith_pkg:
  - default WIDTH = 32
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - function for counter width, clog2
- Sub-module fs (1-bit full subtractor: inputs x, y, br_in; outputs diff, br_out), instantiated once in the datapath, gate-level like the adder's full-adder cell.
- Top level holds the FSM, counter, three shift registers, borrow flop and output registers.

## Test plan
- a=5, b=3, bi=0 → done after 32 cycles; d=0x00000002, bo=0, ovf=0, zero=0.
- a=0, b=1, bi=0 → d=0xFFFFFFFF, bo=1, ovf=0, zero=0.
- a=0x80000000, b=1, bi=0 → d=0x7FFFFFFF, bo=0, ovf=1; then a=0x7FFFFFFF, b=0xFFFFFFFF → d=0x80000000, bo=1, ovf=1.
- a=7, b=7, bi=0 → d=0, zero=1, bo=0; same with bi=1 → d=0xFFFFFFFF, bo=1, zero=0.
- start, then start held high with new operands during RUN and during DONE → only the first operation completes. The next start is accepted at the IDLE edge, and done pulses exactly once per accepted start, spaced ≥ 34 cycles apart.
- Reset pulse at RUN cycle 10 → busy/done/d/bo/ovf/zero all 0 immediately, no done pulse. A fresh start then completes correctly (a=5, b=3 → d=2).

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: default operand width, serial FSM
// state encoding and a constant-evaluable ceil(log2) helper.
package arith_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sub_serial_fs.sv
// One-bit full subtractor cell: diff = x - y - br_in, gate-level form that
// mirrors the full-adder cell of the ripple-carry adder.
module fs (
  input  logic x,
  input  logic y,
  input  logic br_in,
  output logic diff,
  output logic br_out
);

  logic x_xor_y;

  assign x_xor_y = x ^ y;
  assign diff    = x_xor_y ^ br_in;
  assign br_out  = (~x & y) | (~x_xor_y & br_in);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial two's-complement subtractor d = a - b - bi, LSB first, one bit
// per clock through a single full-subtractor cell and one borrow flop.
module sub_serial #(
  parameter int WIDTH = arith_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf,
  output logic             zero
);

  import arith_pkg::*;

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam int DW = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the WIDTH-1 most recent difference bits; the final bit is merged
  // straight into the output register on the last RUN cycle.
  logic [DW-1:0]    dsh_q, dsh_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             cell_diff;
  logic             cell_br;
  logic [WIDTH-1:0] d_fin;
  logic             last_bit;

  fs u_fs (
    .x      (a_sh_q[0]),
    .y      (b_sh_q[0]),
    .br_in  (br_q),
    .diff   (cell_diff),
    .br_out (cell_br)
  );

  assign d_fin    = {cell_diff, dsh_q};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    dsh_d   = dsh_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    d_d     = d_q;
    bo_d    = bo_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bi;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
        end
      end
      RUN: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        dsh_d  = DW'({cell_diff, dsh_q} >> 1);
        br_d   = cell_br;
        if (last_bit) begin
          state_d = DONE;
          cnt_d   = '0;
          d_d     = d_fin;
          bo_d    = cell_br;
          ovf_d   = (a_msb_q ^ b_msb_q) & (cell_diff ^ a_msb_q);
          zero_d  = (d_fin == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      dsh_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      dsh_q   <= dsh_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bo   = bo_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
